wb_traffic_gen: RTL
===================

Name: wb_traffic_gen

Overview:
Parametrised Wishbone master that exercises the sdrc_top Wishbone slave without a hand-written testcase. It writes a programmable number of bursts of LFSR data from a base address, then reads the same region back and compares every beat. It counts mismatches and flags ack timeouts. It sits between the bench control logic and the controller's wb_* port, replacing per-test directed write/read tasks.

Parameters:
DW, 32, Wishbone data width; legal values 8, 16, 32.
AW, 26, Wishbone byte-address width.
BLW, 4, width of burst_len; maximum burst is 2**BLW-1 beats.
NBW, 8, width of num_bursts.
SEED, 32'hACE1_2468, LFSR seed loaded at every start; must be non-zero.
TO_CYC, 255, ack timeout in wb_clk_i cycles per beat.

Ports:
wb_clk_i  in  1  single clock for all logic.
wb_rst_i  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle pulse; begins a run when idle.
init_done  in  1  sdr_init_done from the controller; the run waits for it.
base_addr  in  AW  first byte address; low log2(DW/8) bits are ignored (forced 0).
burst_len  in  BLW  beats per burst, sampled at start.
num_bursts  in  NBW  bursts per phase, sampled at start.
wb_cyc_o  out  1  Wishbone cycle.
wb_stb_o  out  1  Wishbone strobe.
wb_we_o  out  1  1 = write phase, 0 = read phase.
wb_addr_o  out  AW  beat byte address.
wb_dat_o  out  DW  write data.
wb_sel_o  out  DW/8  byte enables; always all ones.
wb_cti_o  out  3  cycle type identifier.
wb_ack_i  in  1  slave acknowledge.
wb_dat_i  in  DW  read data.
busy  out  1  high from accepted start until DONE.
done  out  1  sticky; set on entering DONE, cleared by the next accepted start.
err_cnt  out  16  saturating count of read mismatches.
first_err_addr  out  AW  address of the first mismatch; 0 if none.
timeout  out  1  sticky; set on ack timeout, cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, any time, including mid-burst): FSM goes to IDLE. All outputs go to 0, LFSR goes to SEED, all counters go to 0. Bus outputs drop in the same instant; the slave sees an aborted cycle.
- FSM states: IDLE, WAIT_INIT, WR, WR_GAP, RD_PREP, RD, RD_GAP, DONE.
- IDLE: on start, latch burst_len, num_bursts and base_addr; clear done, timeout, err_cnt and first_err_addr; set busy; go to WAIT_INIT. A start seen in any other state is ignored.
- WAIT_INIT: if the latched burst_len==0 or num_bursts==0, go directly to DONE with no bus activity. Otherwise, when init_done=1, go to WR on the next cycle.
- WR/RD: assert cyc and stb with address = current beat address. The beat completes on a cycle where stb & ack are both high. On completion: address += DW/8, beat counter +1, LFSR advances one step.
- End of burst (last beat acked): drop cyc and stb for exactly one cycle (WR_GAP or RD_GAP). Then start the next burst, or advance to the next phase after the final burst.
- RD_PREP: one cycle. Reload LFSR to SEED and address to base_addr; then go to RD.
- Address continues across bursts (burst n+1 starts where burst n ended). Address wraps modulo 2**AW without any flag.
- Write data and expected read data = LFSR[DW-1:0]. The LFSR is 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shifted right.
- Read compare: on a read ack, wb_dat_i is compared to LFSR[DW-1:0]. On mismatch, err_cnt increments, saturating at 16'hFFFF. first_err_addr captures wb_addr_o only when err_cnt==0 before the increment.
- Timeout: a per-beat counter is cleared on each ack. If it reaches TO_CYC with stb high and no ack, drop cyc and stb, set timeout, go to DONE.
- DONE: one cycle, then IDLE. busy=0 in DONE. done stays high until the next accepted start.
- An ack received while stb=0 is ignored.

Optional Feature:
WB_TG_BURST_EN.
- Defined (registered-feedback bursts): stb stays high for every beat of a burst. wb_cti_o = 3'b010 on all beats except the last, and 3'b111 on the last beat.
- Undefined (classic cycles): wb_cti_o = 3'b000 always. After each acked beat, stb drops for one cycle while cyc stays high through the burst. Beat count, data and address sequence are identical to the defined case.

Test Plan:
- Loopback to sdrc_top and SDRAM model; base_addr=0, burst_len=4, num_bursts=8 -> 32 write acks then 32 read acks, done=1, err_cnt=0, timeout=0.
- Same run, bench corrupts read beat 5 (force wb_dat_i bit 0 flipped) -> err_cnt=1, first_err_addr=26'h14.
- Slave model never acks; TO_CYC=255 -> cyc drops 255 cycles after stb rises, timeout=1, done=1, zero acks.
- burst_len=0 with start -> no cyc for the whole run, done=1 within 3 cycles, err_cnt=0.
- wb_rst_i asserted during write beat 3 of burst 2 -> cyc, stb and busy go to 0 immediately. After release, a new start with burst_len=2, num_bursts=1 completes with err_cnt=0.
- Run with and without WB_TG_BURST_EN, burst_len=3 -> cti sequence 010,010,111 versus 000,000,000, with a stb gap only in the undefined build; identical address/data trace.

Source files
------------

// File: rtl/wb_traffic_gen.sv
// ---------------------------------------------------------------------------
// wb_traffic_gen
//
// Wishbone master traffic generator. Writes num_bursts bursts of burst_len
// beats of LFSR data starting at base_addr, then reads the same region back
// and compares every beat against the regenerated LFSR sequence.
// Mismatches are counted, and the address of the first one is captured.
// A per-beat ack timeout aborts the run.
//
// Build option:
//   WB_TG_BURST_EN  defined   : registered-feedback bursts. stb is held for
//                               the whole burst. cti is 010 on every beat
//                               except the last, which uses 111.
//                   undefined : classic cycles. cti is always 000. stb drops
//                               for one cycle after each acked beat, while
//                               cyc stays high for the rest of the burst.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock; asynchronous active-high reset
//   start                  one-cycle pulse that begins a run when idle
//   init_done              SDRAM init complete; the run waits for it
//   base_addr              first byte address; the low bits are forced to 0
//   burst_len, num_bursts  run shape, sampled at start
//   wb_cyc_o .. wb_cti_o   Wishbone master outputs
//   wb_ack_i, wb_dat_i     Wishbone slave responses
//   busy, done             run status (done is sticky until the next start)
//   err_cnt                saturating count of read mismatches
//   first_err_addr         address of the first mismatch
//   timeout                sticky ack-timeout flag
// ---------------------------------------------------------------------------
module wb_traffic_gen #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 26,
    parameter int unsigned BLW    = 4,
    parameter int unsigned NBW    = 8,
    parameter logic [31:0] SEED   = 32'hACE1_2468,
    parameter int unsigned TO_CYC = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic              init_done,
    input  logic [AW-1:0]     base_addr,
    input  logic [BLW-1:0]    burst_len,
    input  logic [NBW-1:0]    num_bursts,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [AW-1:0]     first_err_addr,
    output logic              timeout
);

    localparam int unsigned BPB = DW / 8;
    // The timeout counter only has to hold 0 .. TO_CYC-1.
    localparam int unsigned TOW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

    localparam logic [AW-1:0]  ADDR_STEP  = AW'(BPB);
    localparam logic [AW-1:0]  ALIGN_MASK = ~AW'(BPB - 1);
    localparam logic [31:0]    LFSR_MASK  = 32'h8020_0003;
    localparam logic [TOW-1:0] TO_LAST    = TOW'(TO_CYC - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_INIT = 3'd1;
    localparam logic [2:0] S_WR        = 3'd2;
    localparam logic [2:0] S_WR_GAP    = 3'd3;
    localparam logic [2:0] S_RD_PREP   = 3'd4;
    localparam logic [2:0] S_RD        = 3'd5;
    localparam logic [2:0] S_RD_GAP    = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]     state_q,   state_d;
    logic [BLW-1:0] blen_q,    blen_d;
    logic [NBW-1:0] nb_q,      nb_d;
    logic [AW-1:0]  base_q,    base_d;
    logic [AW-1:0]  addr_q,    addr_d;
    logic [31:0]    lfsr_q,    lfsr_d;
    logic [BLW-1:0] beat_q,    beat_d;
    logic [NBW-1:0] burst_q,   burst_d;
    logic [TOW-1:0] to_q,      to_d;
    logic           busy_q,    busy_d;
    logic           done_q,    done_d;
    logic [15:0]    err_q,     err_d;
    logic [AW-1:0]  ferr_q,    ferr_d;
    logic           tmo_q,     tmo_d;
`ifndef WB_TG_BURST_EN
    logic           gap_q,     gap_d;
`endif

    logic        in_beat;
    logic        last_beat;
    logic        ack_ok;
    logic        rd_mismatch;
    logic [31:0] lfsr_step;

    // Bus outputs are decoded from registered state, so an asynchronous reset
    // removes cyc/stb in the same instant.
    assign in_beat  = (state_q == S_WR) || (state_q == S_RD);
    assign wb_cyc_o = in_beat;
`ifdef WB_TG_BURST_EN
    assign wb_stb_o = in_beat;
`else
    assign wb_stb_o = in_beat & ~gap_q;
`endif
    assign wb_we_o   = (state_q == S_WR) || (state_q == S_WR_GAP);
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = wb_we_o ? lfsr_q[DW-1:0] : '0;
    assign wb_sel_o  = {(DW/8){in_beat}};

    assign last_beat = (beat_q == (blen_q - BLW'(1)));
    assign ack_ok    = wb_stb_o & wb_ack_i;

`ifdef WB_TG_BURST_EN
    assign wb_cti_o = wb_stb_o ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
`else
    assign wb_cti_o = 3'b000;
`endif

    // Galois LFSR, shifted right; feedback taps come from the polynomial mask.
    assign lfsr_step   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
    assign rd_mismatch = (state_q == S_RD) && ack_ok && (wb_dat_i != lfsr_q[DW-1:0]);

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;
    assign timeout        = tmo_q;

    always_comb begin
        state_d = state_q;
        blen_d  = blen_q;
        nb_d    = nb_q;
        base_d  = base_q;
        addr_d  = addr_q;
        lfsr_d  = lfsr_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        to_d    = to_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        tmo_d   = tmo_q;
`ifndef WB_TG_BURST_EN
        gap_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    blen_d  = burst_len;
                    nb_d    = num_bursts;
                    base_d  = base_addr & ALIGN_MASK;
                    addr_d  = base_addr & ALIGN_MASK;
                    lfsr_d  = SEED;
                    beat_d  = '0;
                    burst_d = '0;
                    to_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = '0;
                    ferr_d  = '0;
                    tmo_d   = 1'b0;
                    state_d = S_WAIT_INIT;
                end
            end

            S_WAIT_INIT: begin
                if ((blen_q == '0) || (nb_q == '0)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (init_done) begin
                    state_d = S_WR;
                end
            end

            S_WR, S_RD: begin
                if (ack_ok) begin
                    addr_d = addr_q + ADDR_STEP;
                    lfsr_d = lfsr_step;
                    to_d   = '0;
                    if (rd_mismatch) begin
                        if (err_q == '0) begin
                            ferr_d = addr_q;
                        end
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                    end
                    if (last_beat) begin
                        beat_d  = '0;
                        burst_d = burst_q + NBW'(1);
                        state_d = (state_q == S_WR) ? S_WR_GAP : S_RD_GAP;
                    end else begin
                        beat_d = beat_q + BLW'(1);
`ifndef WB_TG_BURST_EN
                        gap_d  = 1'b1;
`endif
                    end
                end else if (wb_stb_o) begin
                    // Only cycles with stb high count towards the timeout, so
                    // the classic inter-beat gap never eats into the budget.
                    if (to_q == TO_LAST) begin
                        tmo_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        to_d = to_q + TOW'(1);
                    end
                end
            end

            S_WR_GAP: begin
                state_d = (burst_q == nb_q) ? S_RD_PREP : S_WR;
            end

            S_RD_PREP: begin
                lfsr_d  = SEED;
                addr_d  = base_q;
                beat_d  = '0;
                burst_d = '0;
                to_d    = '0;
                state_d = S_RD;
            end

            S_RD_GAP: begin
                if (burst_q == nb_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_RD;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            blen_q  <= '0;
            nb_q    <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            lfsr_q  <= SEED;
            beat_q  <= '0;
            burst_q <= '0;
            to_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            tmo_q   <= 1'b0;
`ifndef WB_TG_BURST_EN
            gap_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            blen_q  <= blen_d;
            nb_q    <= nb_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            lfsr_q  <= lfsr_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            tmo_q   <= tmo_d;
`ifndef WB_TG_BURST_EN
            gap_q   <= gap_d;
`endif
        end
    end

endmodule
